// File: rtl/cpu0_mem_responder.sv
// Clocked, handshaked memory slave for the CPU0 core: big-endian byte storage,
// programmable wait states, range checking and a byte-wide preload port.
//
//   state  | meaning
//   S_IDLE | accepts a preload byte or captures a CPU request
//   S_WAIT | wait-state countdown, then performs the access
//   S_ACK  | holds ack/err/dbus until the CPU drops en
module cpu0_mem_responder #(
  parameter int DEPTH       = 128,
  parameter int WAIT_STATES = 2,
  parameter int AW          = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          en,
  input  logic          rw,
  input  logic [AW-1:0] abus,
  input  logic [31:0]   dbus_in,
  output logic [31:0]   dbus_out,
  output logic          dbus_oe,
  output logic          ack,
  output logic          err,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data
);

  localparam int            IW        = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 4);
  localparam logic [AW-1:0] MEM_SIZE  = AW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t        state, state_nx;
  logic [3:0]    cnt, cnt_nx;
  logic [AW-1:0] req_addr, req_addr_nx;
  logic          req_rw, req_rw_nx;
  logic [31:0]   req_data, req_data_nx;
  logic          ack_nx, err_nx, oe_nx;
  logic [31:0]   dout_nx;
  logic          ld_we, acc_we;
  logic          req_ok;
  logic [IW-1:0] a0, a1, a2, a3, ld_idx;
  logic [31:0]   rd_word;

  logic [7:0] mem [DEPTH];

  // Unsigned compare over the full address width, so high addresses never wrap.
  assign req_ok  = (req_addr <= LAST_WORD);
  assign a0      = req_addr[IW-1:0];
  assign a1      = a0 + IW'(1);
  assign a2      = a0 + IW'(2);
  assign a3      = a0 + IW'(3);
  assign ld_idx  = ld_addr[IW-1:0];
  assign rd_word = {mem[a0], mem[a1], mem[a2], mem[a3]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      req_addr <= '0;
      req_rw   <= 1'b0;
      req_data <= 32'h0;
      ack      <= 1'b0;
      err      <= 1'b0;
      dbus_oe  <= 1'b0;
      dbus_out <= 32'h0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      req_addr <= req_addr_nx;
      req_rw   <= req_rw_nx;
      req_data <= req_data_nx;
      ack      <= ack_nx;
      err      <= err_nx;
      dbus_oe  <= oe_nx;
      dbus_out <= dout_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    req_addr_nx = req_addr;
    req_rw_nx   = req_rw;
    req_data_nx = req_data;
    ack_nx      = ack;
    err_nx      = err;
    oe_nx       = dbus_oe;
    dout_nx     = dbus_out;
    ld_we       = 1'b0;
    acc_we      = 1'b0;
    case (state)
      S_IDLE: begin
        // Preload wins; a held request is picked up once ld_en falls.
        if (ld_en) begin
          ld_we = (ld_addr < MEM_SIZE);
        end else if (en) begin
          req_addr_nx = abus;
          req_rw_nx   = rw;
          req_data_nx = dbus_in;
          cnt_nx      = 4'(WAIT_STATES);
          state_nx    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt != 4'd0) begin
          cnt_nx = cnt - 4'd1;
        end else begin
          ack_nx   = 1'b1;
          state_nx = S_ACK;
          if (!req_ok) begin
            err_nx = 1'b1;
            if (req_rw) begin
              dout_nx = 32'hFFFF_FFFF;
              oe_nx   = 1'b1;
            end
          end else begin
            err_nx = 1'b0;
            if (req_rw) begin
              dout_nx = rd_word;
              oe_nx   = 1'b1;
            end else begin
              acc_we = 1'b1;
            end
          end
        end
      end
      S_ACK: begin
        if (!en) begin
          ack_nx   = 1'b0;
          err_nx   = 1'b0;
          oe_nx    = 1'b0;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Storage survives reset; reset only suppresses a write landing on the same edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (ld_we) begin
        mem[ld_idx] <= ld_data;
      end
      if (acc_we) begin
        mem[a0] <= req_data[31:24];
        mem[a1] <= req_data[23:16];
        mem[a2] <= req_data[15:8];
        mem[a3] <= req_data[7:0];
      end
    end
  end

endmodule

// File: tb/tb_cpu0_mem_responder.sv
// Bench for cpu0_mem_responder: two instances (0 and 2 wait states) share stimulus
// and are checked every cycle against a transaction-level memory/timing model.
module tb_cpu0_mem_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0, rw = 1'b0, ld_en = 1'b0;
  logic [31:0] abus = '0, dbus_in = '0, ld_addr = '0;
  logic [7:0]  ld_data = '0;
  logic [31:0] dout [2];
  logic        oe [2], ack [2], err [2];

  always #5 clock = ~clock;

  cpu0_mem_responder #(.DEPTH(128), .WAIT_STATES(0), .AW(32)) u_ws0 (
    .clock(clock), .reset(reset), .en(en), .rw(rw), .abus(abus), .dbus_in(dbus_in),
    .dbus_out(dout[0]), .dbus_oe(oe[0]), .ack(ack[0]), .err(err[0]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  cpu0_mem_responder #(.DEPTH(128), .WAIT_STATES(2), .AW(32)) u_ws2 (
    .clock(clock), .reset(reset), .en(en), .rw(rw), .abus(abus), .dbus_in(dbus_in),
    .dbus_out(dout[1]), .dbus_oe(oe[1]), .ack(ack[1]), .err(err[1]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  bit chk_on   = 1'b0;
  int ws [2]   = '{0, 2};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: one pending request per instance, ack edge is
  // capture edge + 1 + wait states, ack held until an edge samples en low.
  bit          m_busy [2];
  int          m_ack_at [2];
  logic [31:0] m_addr [2], m_wdata [2];
  logic        m_rd [2];
  logic [7:0]  mm [2][128];
  logic [31:0] e_dout [2];
  logic        e_ack [2], e_err [2], e_oe [2];

  function automatic logic [31:0] mword(input int k, input int a);
    return {mm[k][a], mm[k][a+1], mm[k][a+2], mm[k][a+3]};
  endfunction

  always @(posedge clock) begin
    cyc = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_busy[k] = 1'b0;
        e_ack[k] = 1'b0; e_err[k] = 1'b0; e_oe[k] = 1'b0; e_dout[k] = 32'h0;
      end else if (!m_busy[k]) begin
        if (ld_en) begin
          if (ld_addr < 32'd128) mm[k][ld_addr[6:0]] = ld_data;
        end else if (en) begin
          m_busy[k] = 1'b1;
          m_ack_at[k] = cyc + 1 + ws[k];
          m_addr[k] = abus; m_rd[k] = rw; m_wdata[k] = dbus_in;
        end
      end else if (cyc == m_ack_at[k]) begin
        e_ack[k] = 1'b1;
        if (m_addr[k] > 32'd124) begin
          e_err[k] = 1'b1;
          if (m_rd[k]) begin e_dout[k] = 32'hFFFF_FFFF; e_oe[k] = 1'b1; end
        end else begin
          e_err[k] = 1'b0;
          if (m_rd[k]) begin
            e_dout[k] = mword(k, int'(m_addr[k]));
            e_oe[k] = 1'b1;
          end else begin
            for (int j = 0; j < 4; j++)
              mm[k][int'(m_addr[k]) + j] = m_wdata[k][31 - 8*j -: 8];
          end
        end
      end else if (cyc > m_ack_at[k] && !en) begin
        e_ack[k] = 1'b0; e_err[k] = 1'b0; e_oe[k] = 1'b0;
        m_busy[k] = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("ack_ws%0d", ws[k]), 32'(ack[k]), 32'(e_ack[k]));
        check($sformatf("err_ws%0d", ws[k]), 32'(err[k]), 32'(e_err[k]));
        check($sformatf("oe_ws%0d", ws[k]), 32'(oe[k]), 32'(e_oe[k]));
        check($sformatf("dout_ws%0d", ws[k]), dout[k], e_dout[k]);
      end
    end
  end

  logic [31:0] r_dout [2];
  logic        r_err [2];
  int          t_ack [2];

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clock);
    ld_en = 1'b0;
  endtask

  // Full four-phase transfer; request inputs and a stray preload are scrambled
  // during the wait so only the latched request may matter.
  task automatic xfer(input logic r, input logic [31:0] a, input logic [31:0] wd);
    int cap;
    en = 1'b1; rw = r; abus = a; dbus_in = wd;
    cap = cyc + 1;
    t_ack[0] = -1; t_ack[1] = -1;
    @(negedge clock);
    abus = $urandom; dbus_in = $urandom; rw = 1'($urandom);
    ld_en = 1'b1; ld_addr = $urandom_range(0, 127); ld_data = 8'($urandom);
    for (int i = 0; i < 20 && (t_ack[0] < 0 || t_ack[1] < 0); i++) begin
      @(negedge clock);
      ld_en = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (ack[k] === 1'b1 && t_ack[k] < 0) begin
          t_ack[k] = cyc; r_dout[k] = dout[k]; r_err[k] = err[k];
        end
      end
    end
    ld_en = 1'b0;
    for (int k = 0; k < 2; k++)
      check($sformatf("ack_edge_ws%0d", ws[k]), 32'(t_ack[k]), 32'(cap + 1 + ws[k]));
    en = 1'b0;
    @(negedge clock);
  endtask

  task automatic abort_xfer(input logic r, input logic [31:0] a, input logic [31:0] wd);
    int hi [2];
    hi[0] = 0; hi[1] = 0;
    en = 1'b1; rw = r; abus = a; dbus_in = wd;
    @(negedge clock);
    en = 1'b0;
    repeat (6) begin
      @(negedge clock);
      for (int k = 0; k < 2; k++) if (ack[k] === 1'b1) hi[k]++;
    end
    for (int k = 0; k < 2; k++)
      check($sformatf("abort_pulse_ws%0d", ws[k]), 32'(hi[k]), 32'd1);
  endtask

  task automatic check_lit(input string name, input logic [31:0] d, input logic e);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_dout_ws%0d", name, ws[k]), r_dout[k], d);
      check($sformatf("%s_err_ws%0d", name, ws[k]), 32'(r_err[k]), 32'(e));
    end
  endtask

  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL global_timeout: got edge %0d expected completion", cyc);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk_on = 1'b1;

    for (int a = 0; a < 128; a++) preload(32'(a), 8'($urandom));
    preload(32'd0, 8'h00); preload(32'd1, 8'h1F); preload(32'd2, 8'h00); preload(32'd3, 8'h18);
    preload(32'd36, 8'h00);
    preload(32'd8, 8'h11); preload(32'd9, 8'h22); preload(32'd10, 8'h33); preload(32'd11, 8'h44);
    preload(32'd300, 8'hAA);

    xfer(1'b1, 32'd0, 32'h0);               check_lit("rd0", 32'h001F_0018, 1'b0);
    xfer(1'b0, 32'd32, 32'hDEAD_BEEF);
    xfer(1'b1, 32'd32, 32'h0);              check_lit("rd32", 32'hDEAD_BEEF, 1'b0);
    xfer(1'b1, 32'd33, 32'h0);              check_lit("rd33", 32'hADBE_EF00, 1'b0);
    xfer(1'b1, 32'd125, 32'h0);             check_lit("rd125", 32'hFFFF_FFFF, 1'b1);
    xfer(1'b0, 32'd200, 32'h1234_5678);
    for (int k = 0; k < 2; k++) check($sformatf("wr200_err_ws%0d", ws[k]), 32'(r_err[k]), 32'd1);
    xfer(1'b1, 32'hFFFF_FFFC, 32'h0);       check_lit("rdtop", 32'hFFFF_FFFF, 1'b1);
    xfer(1'b1, 32'd124, 32'h0);
    for (int k = 0; k < 2; k++) check($sformatf("rd124_err_ws%0d", ws[k]), 32'(r_err[k]), 32'd0);

    abort_xfer(1'b1, 32'd4, 32'h0);
    abort_xfer(1'b0, 32'd40, 32'hCAFE_F00D);
    xfer(1'b1, 32'd40, 32'h0);              check_lit("rd40", 32'hCAFE_F00D, 1'b0);

    // Reset lands on the edge after capture of a write to 8.
    en = 1'b1; rw = 1'b0; abus = 32'd8; dbus_in = 32'h5555_AAAA;
    @(negedge clock);
    reset = 1'b1; en = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_ack_ws%0d", ws[k]), 32'(ack[k]), 32'd0);
      check($sformatf("rst_oe_ws%0d", ws[k]), 32'(oe[k]), 32'd0);
      check($sformatf("rst_dout_ws%0d", ws[k]), dout[k], 32'h0);
    end
    @(negedge clock);
    xfer(1'b1, 32'd8, 32'h0);               check_lit("rd8", 32'h1122_3344, 1'b0);

    // Preload and request together: capture waits for ld_en to fall.
    ld_en = 1'b1; ld_addr = 32'd64; ld_data = 8'h9C;
    en = 1'b1; rw = 1'b1; abus = 32'd64;
    @(negedge clock);
    @(negedge clock);
    ld_en = 1'b0;
    xfer(1'b1, 32'd64, 32'h0);
    for (int k = 0; k < 2; k++) check($sformatf("ldprio_ws%0d", ws[k]), 32'(r_dout[k][31:24]), 32'h9C);

    repeat (150) begin
      int op;
      logic [31:0] a;
      op = $urandom_range(0, 9);
      a = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 127));
      if (op == 0)      preload(32'($urandom_range(0, 135)), 8'($urandom));
      else if (op == 1) abort_xfer(1'($urandom), a, $urandom);
      else              xfer(1'($urandom), a, $urandom);
    end

    for (int a = 0; a <= 124; a += 4) xfer(1'b1, 32'(a), 32'h0);

    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/cpu0_mem_responder.md
Name: cpu0_mem_responder

Overview:
- Bus-side memory responder for the CPU0 multi-cycle core. Answers the CPU's memory strobe (m_en), direction (m_rw), address bus and data bus.
- Replaces the purely combinational memory model with a clocked, handshaked slave. It has programmable wait states, big-endian byte-addressed storage, range checking and a byte-wide preload port used by benches and boot code.
- Sits between cpu0 and the top-level computer module; the top level drives its tri-state data bus using dbus_oe.

Parameters:
- DEPTH, 128, storage size in bytes; valid word addresses are 0..DEPTH-4.
- WAIT_STATES, 2, extra cycles between request capture and access (0..15).
- AW, 32, address bus width.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  CPU memory strobe (m_en); request when high.
- rw  in  1  1 = read, 0 = write (m_rw).
- abus  in  AW  byte address (CPU mar).
- dbus_in  in  32  write data from the CPU (CPU mdr).
- dbus_out  out  32  read data to the CPU.
- dbus_oe  out  1  top level drives dbus from dbus_out when high, Z otherwise.
- ack  out  1  access complete; dbus_out is valid when ack=1 and rw=1.
- err  out  1  out-of-range access; qualified by ack.
- ld_en  in  1  preload byte write strobe.
- ld_addr  in  AW  preload byte address.
- ld_data  in  8  preload byte.

Behaviour:
- Reset (synchronous, priority over everything):
  - State goes to IDLE; ack=0, err=0, dbus_oe=0, dbus_out=32'h0, wait counter=0.
  - Any in-flight write is discarded. Storage contents are retained, not cleared.
- Storage is a byte array m[0..DEPTH-1], big-endian:
  - The word at address A is {m[A], m[A+1], m[A+2], m[A+3]}.
  - Unaligned A is legal.
- FSM states: IDLE, WAIT, ACK.
  - IDLE, ld_en=1: write m[ld_addr] <= ld_data, provided ld_addr < DEPTH; out-of-range preloads are dropped silently. The CPU request is not captured this cycle, so ld_en has priority and the held en is served on a later edge.
  - IDLE, en=1 and ld_en=0 at edge N: latch abus, rw and dbus_in; cnt <= WAIT_STATES; go to WAIT.
  - WAIT, cnt != 0: cnt <= cnt-1. The latched request is used, so changes on abus, rw or dbus_in are ignored.
  - WAIT, cnt == 0: perform the access, set ack=1, go to ACK. ack therefore rises at edge N+1+WAIT_STATES (WAIT_STATES=0 gives 1-cycle latency).
  - Read access: dbus_out <= word, dbus_oe=1, err=0.
  - Write access: the 4 bytes are written at this edge, dbus_oe stays 0, dbus_out is unchanged.
  - Range error (addr > DEPTH-4): no storage change; err=1 with ack; a read returns dbus_out=32'hFFFFFFFF with dbus_oe=1.
  - ACK: four-phase handshake. Hold ack, err, dbus_out and dbus_oe while en=1. At the first edge with en=0: ack=0, err=0, dbus_oe=0, return to IDLE. dbus_out keeps its last value.
- ld_en outside IDLE is ignored.
- en dropped during WAIT (an abort): the access still completes. ack is then asserted for exactly one cycle and the FSM returns to IDLE, because en is already 0.
- A new request is never accepted before the FSM passes through IDLE. Back-to-back requests need en low for at least one edge.
- A read of bytes written earlier returns the written value. A write followed immediately by a read of the same address returns the new data.
- Address comparison is unsigned over the full AW bits. An address of 32'hFFFFFFFC is out of range with no wrap-around.

Test Plan:
- Preload 32'h001F0018 at bytes 0..3 via ld_en, then read addr 0 with WAIT_STATES=2 and en rising at edge 10 -> ack=1 from edge 13, dbus_out=32'h001F0018, dbus_oe=1, err=0. Drop en at edge 15 -> ack=0 and dbus_oe=0 after edge 15.
- Write 32'hDEADBEEF at addr 32 then read addr 32 -> 32'hDEADBEEF. Read addr 33 -> 32'hADBEEF00, given m[36]=0 (unaligned, big-endian).
- Read addr 125 with DEPTH=128 -> ack with err=1 and dbus_out=32'hFFFFFFFF. Write addr 200 -> ack with err=1, and bytes 0..127 are unchanged on readback.
- Change abus from 0 to 4 during WAIT -> the returned data is the word at address 0. Drop en during WAIT -> single-cycle ack, and the FSM is in IDLE on the next edge.
- Assert reset during WAIT of a write to addr 8 -> ack never rises, m[8..11] keep their old value, and all outputs are at reset values on the next edge. Run with WAIT_STATES=0 -> ack at edge N+1.
- Hold ld_en=1 and en=1 together in IDLE -> the preload byte is written first and the request is captured on the next edge after ld_en falls. Check the ack timing shift.
